// File: rtl/dff_pkg.sv
// -----------------------------------------------------------------------------
// dff_pkg
// Shared constants and helpers for the register cells (dff, dff_stage).
//   DFF_MAX_STAGES   : deepest delay line a register cell may be built with
//   DFF_RESET_BIT    : bit value replicated to form the default reset value
//   dff_params_legal : elaboration-time legality check of width / depth
// Optional feature macro used by the cells importing this package:
//   DFF_ENABLE_EN (adds a clock-enable input)
// -----------------------------------------------------------------------------
package dff_pkg;

  localparam int unsigned DFF_MAX_STAGES = 32'd16;
  localparam logic        DFF_RESET_BIT  = 1'b0;

  // True when the register geometry can be built: at least one bit wide and
  // between one and max_stages stages deep.
  function automatic bit dff_params_legal(
    input int unsigned width,
    input int unsigned stages,
    input int unsigned max_stages
  );
    bit legal;
    legal = (width >= 32'd1) && (stages >= 32'd1) && (stages <= max_stages);
    return legal;
  endfunction

endpackage : dff_pkg

// File: rtl/dff_stage.sv
// -----------------------------------------------------------------------------
// dff_stage
// One WIDTH-bit rising-edge register with synchronous active-high reset.
// Ports:
//   clk : clock, rising edge only
//   rst : synchronous reset, loads RESET_VAL
//   en  : clock enable, present only when DFF_ENABLE_EN is defined;
//         rst has priority over en
//   d   : data input
//   q   : registered output
// Optional feature macro: DFF_ENABLE_EN
// -----------------------------------------------------------------------------
module dff_stage
  import dff_pkg::*;
#(
  parameter int unsigned          WIDTH     = 32'd1,
  parameter logic [WIDTH-1:0]     RESET_VAL = {WIDTH{DFF_RESET_BIT}}
) (
  input  logic             clk,
  input  logic             rst,
`ifdef DFF_ENABLE_EN
  input  logic             en,
`endif
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  // Next-state selection: reset first, then (optionally) hold, else capture.
  always_comb begin
    data_d = data_q;
    if (rst) begin
      data_d = RESET_VAL;
    end
`ifdef DFF_ENABLE_EN
    else if (en) begin
      data_d = d;
    end else begin
      data_d = data_q;
    end
`else
    else begin
      data_d = d;
    end
`endif
  end

  // State register; no asynchronous path, reset is folded into data_d.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign q = data_q;

endmodule : dff_stage

// File: rtl/dff.sv
// -----------------------------------------------------------------------------
// dff
// Parameterised D flip-flop / fixed-latency delay line built from STAGES
// cascaded dff_stage registers. q is the last stage, so there is never a
// combinational path from d to q; latency is STAGES clock edges.
// Parameters:
//   WIDTH     : data width of d and q
//   STAGES    : number of register stages, 1..DFF_MAX_STAGES
//   RESET_VAL : value loaded into every stage while rst is high
// Ports:
//   clk : clock, rising edge only
//   rst : synchronous reset, active-high; flushes all in-flight data
//   en  : clock enable for every stage, present only with DFF_ENABLE_EN;
//         rst has priority over en
//   d   : data input
//   q   : registered output (last stage)
// Optional feature macro: DFF_ENABLE_EN
// -----------------------------------------------------------------------------
module dff
  import dff_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32'd1,
  parameter int unsigned      STAGES    = 32'd1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{DFF_RESET_BIT}}
) (
  input  logic             clk,
  input  logic             rst,
`ifdef DFF_ENABLE_EN
  input  logic             en,
`endif
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reject illegal geometry while elaborating rather than building a
  // degenerate (zero-depth or oversized) chain.
  if (!dff_params_legal(WIDTH, STAGES, DFF_MAX_STAGES)) begin : g_illegal
    $error("dff: illegal parameters WIDTH=%0d STAGES=%0d (STAGES must be 1..%0d)",
           WIDTH, STAGES, DFF_MAX_STAGES);
  end

  // stage_in[i] feeds stage i; stage 0 takes d, others take the previous stage.
  logic [WIDTH-1:0] stage_in [STAGES];
  logic [WIDTH-1:0] stage_q  [STAGES];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign stage_in[i] = d;
    end else begin : g_link
      assign stage_in[i] = stage_q[i-1];
    end

    dff_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk (clk),
      .rst (rst),
`ifdef DFF_ENABLE_EN
      .en  (en),
`endif
      .d   (stage_in[i]),
      .q   (stage_q[i])
    );
  end

  assign q = stage_q[STAGES-1];

endmodule : dff

// File: tb/tb_dff.sv
// -----------------------------------------------------------------------------
// tb_dff
// Self-checking bench for dff. Four instances run off one 100 ns clock
// (rising edges at 50, 150, 250 ns ...). Inputs are driven and outputs
// sampled on the falling edge, away from the capturing edge.
//   u0 : WIDTH=1,  STAGES=1                     basic capture, glitches
//   u1 : WIDTH=8,  STAGES=1, RESET_VAL=8'hA5    reset behaviour, enable
//   u2 : WIDTH=8,  STAGES=3, RESET_VAL=0        latency and flush
//   u3 : WIDTH=16, STAGES=4, RESET_VAL=16'h1234 random vs queue model
// -----------------------------------------------------------------------------
module tb_dff;

  logic        clk;
  logic        rst0, rst1, rst2, rst3;
  logic [0:0]  d0;
  logic [7:0]  d1, d2;
  logic [15:0] d3;
  logic [0:0]  q0;
  logic [7:0]  q1, q2;
  logic [15:0] q3;
`ifdef DFF_ENABLE_EN
  logic        en0, en1, en2, en3;
`endif

  int n_cmp;
  int n_err;

  dff #(.WIDTH(1), .STAGES(1)) u0 (
    .clk(clk), .rst(rst0),
`ifdef DFF_ENABLE_EN
    .en(en0),
`endif
    .d(d0), .q(q0));

  dff #(.WIDTH(8), .STAGES(1), .RESET_VAL(8'hA5)) u1 (
    .clk(clk), .rst(rst1),
`ifdef DFF_ENABLE_EN
    .en(en1),
`endif
    .d(d1), .q(q1));

  dff #(.WIDTH(8), .STAGES(3), .RESET_VAL(8'h00)) u2 (
    .clk(clk), .rst(rst2),
`ifdef DFF_ENABLE_EN
    .en(en2),
`endif
    .d(d2), .q(q2));

  dff #(.WIDTH(16), .STAGES(4), .RESET_VAL(16'h1234)) u3 (
    .clk(clk), .rst(rst3),
`ifdef DFF_ENABLE_EN
    .en(en3),
`endif
    .d(d3), .q(q3));

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance across one rising edge and stop at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hand-computed expectations for u2 after each d value (d=1..6 then flush).
  logic [7:0] lat_d   [6] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
  logic [7:0] lat_exp [6] = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4};

  logic [15:0] pipe[$];
  logic [15:0] rv3;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rv3   = 16'h1234;
    rst0 = 1'b0; d0 = 1'b0;
    rst1 = 1'b1; d1 = 8'h00;
    rst2 = 1'b1; d2 = 8'h00;
    rst3 = 1'b1; d3 = 16'h0000;
`ifdef DFF_ENABLE_EN
    en0 = 1'b1; en1 = 1'b1; en2 = 1'b1; en3 = 1'b1;
`endif

    // ---- basic capture, no reset on u0 ----
    step();                                   // edge at 50, now t=100
    check_eq("cap_0", 64'(q0), 64'h0);
    d0 = 1'b1;
    step();                                   // edge at 150
    check_eq("cap_1", 64'(q0), 64'h1);
    d0 = 1'b0;
    step();                                   // edge at 250
    check_eq("cap_0b", 64'(q0), 64'h0);

    // ---- glitch between edges ----
    #10 d0 = 1'b1;
    #10 d0 = 1'b0;
    step();
    check_eq("glitch_hi", 64'(q0), 64'h0);
    d0 = 1'b1;
    step();
    check_eq("cap_1b", 64'(q0), 64'h1);
    #10 d0 = 1'b0;
    #10 d0 = 1'b1;
    step();
    check_eq("glitch_lo", 64'(q0), 64'h1);

    // ---- reset behaviour on u1 ----
    rst1 = 1'b1; d1 = 8'h3C;
    step();
    check_eq("rst_load", 64'(q1), 64'hA5);
    rst1 = 1'b0;
    step();
    check_eq("rst_rel", 64'(q1), 64'h3C);
    rst1 = 1'b1; d1 = 8'hFF;
    step();
    check_eq("rst_wins", 64'(q1), 64'hA5);
    rst1 = 1'b0;
    step();
    check_eq("after_rst", 64'(q1), 64'hFF);

`ifdef DFF_ENABLE_EN
    // ---- clock enable on u1 ----
    d1 = 8'h11;
    step();
    check_eq("en_cap", 64'(q1), 64'h11);
    en1 = 1'b0;
    d1 = 8'h22; step(); check_eq("en_hold0", 64'(q1), 64'h11);
    d1 = 8'h33; step(); check_eq("en_hold1", 64'(q1), 64'h11);
    d1 = 8'h44; step(); check_eq("en_hold2", 64'(q1), 64'h11);
    rst1 = 1'b1;
    step();
    check_eq("en_rst", 64'(q1), 64'hA5);
    rst1 = 1'b0; d1 = 8'h55;
    step();
    check_eq("en_hold_rv", 64'(q1), 64'hA5);
    en1 = 1'b1; d1 = 8'h66;
    step();
    check_eq("en_resume", 64'(q1), 64'h66);
`endif

    // ---- latency and flush on u2 (STAGES=3) ----
    rst2 = 1'b1;
    step();
    check_eq("lat_rst", 64'(q2), 64'h0);
    rst2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d2 = lat_d[i];
      step();
      check_eq($sformatf("lat_%0d", i), 64'(q2), 64'(lat_exp[i]));
    end
    // In flight now: 6 (stage0), 5 (stage1). Reset must discard both.
    rst2 = 1'b1; d2 = 8'd7;
    step();
    check_eq("flush_rst", 64'(q2), 64'h0);
    rst2 = 1'b0;
    d2 = 8'd8;  step(); check_eq("flush_0", 64'(q2), 64'h0);
    d2 = 8'd9;  step(); check_eq("flush_1", 64'(q2), 64'h0);
    d2 = 8'd10; step(); check_eq("flush_2", 64'(q2), 64'h8);
    step();             check_eq("flush_3", 64'(q2), 64'h9);

    // ---- random traffic on u3 against a queue model ----
    rst3 = 1'b1;
    step();
    pipe.delete();
    for (int i = 0; i < 4; i++) pipe.push_back(rv3);
    check_eq("rnd_rst", 64'(q3), 64'(rv3));
    for (int cyc = 0; cyc < 1000; cyc++) begin
      logic r_v;
      logic e_v;
      d3  = 16'($urandom);
      r_v = ($urandom_range(0, 19) == 0);
      e_v = 1'b1;
`ifdef DFF_ENABLE_EN
      e_v = ($urandom_range(0, 3) != 0);
      en3 = e_v;
`endif
      rst3 = r_v;
      step();
      if (r_v) begin
        pipe.delete();
        for (int i = 0; i < 4; i++) pipe.push_back(rv3);
      end else if (e_v) begin
        pipe.push_back(d3);
        void'(pipe.pop_front());
      end
      check_eq($sformatf("rnd_%0d", cyc), 64'(q3), 64'(pipe[0]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_dff

// File: doc/dff.md
Name: dff

Overview:
- Parameterised edge-triggered D flip-flop / register primitive with synchronous active-high reset.
- Captures `d` on the rising edge of `clk` and presents it on `q`.
- Optionally chains several stages to form a fixed-latency delay line.
- Leaf cell used wherever the design needs a registered signal or a retiming stage.

Parameters:
- WIDTH, 1, bit width of `d` and `q`.
- STAGES, 1, number of cascaded register stages (latency in cycles); legal range 1..16.
- RESET_VAL, 0 (WIDTH bits), value loaded into every stage while `rst` is high.

Ports:
- clk  input  1  clock; all state changes on the rising edge only.
- rst  input  1  synchronous reset, active-high.
- d  input  WIDTH  data input, sampled at each rising edge.
- q  output  WIDTH  registered output, equal to the last stage.
- Port order is clk, rst, d, q. Always connect by name.

Behaviour:
- One clock (`clk`). Reset is synchronous and active-high. No asynchronous paths.
- Each rising edge with `rst`=0:
  - stage[0] <= d
  - stage[i] <= stage[i-1] for i = 1..STAGES-1
  - q = stage[STAGES-1]
- Latency: `d` sampled at edge N appears on `q` immediately after edge N+STAGES-1. With STAGES=1, `q` changes right after the capturing edge.
- `q` is purely registered; there is no combinational path from `d` to `q`.
- `d` changes between edges have no effect until the next rising edge. The falling edge is ignored.
- Reset:
  - `rst`=1 at a rising edge loads RESET_VAL into all stages; `q`=RESET_VAL after that edge.
  - `rst` asserted mid-operation discards all in-flight data in the same edge.
  - `rst` is not sampled between edges.
- Simultaneous `rst`=1 and a `d` change at an edge: reset wins; `d` is dropped.
- First edge after `rst` deasserts: stage[0] captures `d`. Later stages keep shifting RESET_VAL until flushed, so `q` stays RESET_VAL for STAGES-1 more edges.
- Power-up, before any edge or reset: contents are unspecified (X in simulation). The block needs no reset to function; after STAGES edges `q` is fully determined by `d`.
- Width: no truncation or extension. `d`, `q` and RESET_VAL are all WIDTH bits.
- Illegal STAGES (0 or >16): elaboration-time error.

Optional Feature:
- Macro DFF_ENABLE_EN.
- Defined:
  - Adds port `en` (input, 1 bit, after `rst`).
  - With `en`=0 at an edge, all stages hold their value.
  - `rst` has priority over `en`; reset applies regardless of `en`.
- Undefined:
  - No `en` port.
  - Stages update on every edge, identical to permanently enabled.

Decomposition:
- Package dff_pkg holds:
  - DFF_MAX_STAGES = 16
  - default RESET_VAL constant
  - a parameter-legality check function shared with other register cells
- Sub-module dff_stage: one WIDTH-bit register with synchronous reset, plus optional enable under DFF_ENABLE_EN.
- Top generates STAGES instances of dff_stage in a chain.

Test Plan:
- Basic capture, WIDTH=1, STAGES=1, 100 ns clock starting low (rising edges at 50, 150, 250 ns), `d`=0 at 0 ns, 1 at 100 ns, 0 at 200 ns, no reset -> `q`=X before 50 ns, 0 after 50, 1 after 150, 0 after 250.
- Glitch immunity: `d` pulses 0->1->0 entirely between two rising edges -> `q` unchanged.
- Reset, WIDTH=8, RESET_VAL=8'hA5, `d`=8'h3C:
  - `rst`=1 for one edge -> `q`=8'hA5.
  - `rst`=0 at the next edge -> `q`=8'h3C.
  - `rst`=1 concurrent with `d`=8'hFF -> `q`=8'hA5.
- Latency, STAGES=3, `d` sequence 1,2,3,4 on consecutive edges after reset with RESET_VAL=0:
  - `q` = 0, 0, 1, 2, 3, 4 on successive edges.
  - Mid-stream `rst` -> `q`=0 on the next edge, and the pipeline is flushed.
- DFF_ENABLE_EN defined:
  - `en`=0 for 3 edges while `d` toggles -> `q` holds.
  - `en`=0 with `rst`=1 -> `q`=RESET_VAL.
  - `en`=1 -> `q` follows `d` again.
- Randomised: 1000 cycles of random `d`/`rst`, WIDTH=16, STAGES=4 -> `q` matches a reference queue model every cycle.
